// File: rtl/camera_frame_writer.sv
// camera_frame_writer: RGB565 -> gray, DECIMxDECIM decimation, double-banked frame buffer writer.
// Ports:
//   p_clock_i      pixel clock (only clock)
//   rst_n_i        synchronous active-low reset
//   pixel_data_i   RGB565 pixel R[15:11] G[10:5] B[4:0]
//   pixel_valid_i  single-cycle pixel qualifier
//   frame_done_i   single-cycle end-of-frame pulse
//   wr_en_o        frame buffer write strobe
//   wr_addr_o      write address within the bank
//   wr_data_o      8-bit grayscale pixel
//   wr_bank_o      bank currently being written
//   rd_bank_o      bank holding the last complete frame
//   frame_ready_o  pulse: rd_bank_o now holds a fresh complete frame
//   frame_error_o  pulse: frame ended with the wrong pixel count
module camera_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 4,
  parameter int OUT_W    = H_ACTIVE / DECIM,
  parameter int OUT_H    = V_ACTIVE / DECIM,
  parameter int ADDR_W   = 15
) (
  input  logic              p_clock_i,
  input  logic              rst_n_i,
  input  logic [15:0]       pixel_data_i,
  input  logic              pixel_valid_i,
  input  logic              frame_done_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              wr_bank_o,
  output logic              rd_bank_o,
  output logic              frame_ready_o,
  output logic              frame_error_o
);
  localparam int PIX  = H_ACTIVE * V_ACTIVE;
  localparam int AMAX = OUT_W * OUT_H;
  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = $clog2(V_ACTIVE + 1);
  localparam int CW   = $clog2(PIX + 2);
  typedef enum logic [1:0] {ACTIVE, FLUSH, SWAP} state_t;
  state_t            state_q;
  logic              flush_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              s1_v_q;
  logic [15:0]       s1_sum_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              wr_en_q, wr_bank_q, rd_bank_q, frame_ready_q, frame_error_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              accept, x_wrap, in_frame, keep;
  logic [15:0]       r8, g8, b8, sum_d;
  always_comb begin
    accept   = (state_q == ACTIVE) && pixel_valid_i;
    x_wrap   = x_q == XW'(H_ACTIVE - 1);
    // y stops at V_ACTIVE so overflow lines stay out of the frame instead of wrapping back in
    in_frame = y_q < YW'(V_ACTIVE);
    keep     = accept && in_frame && ((x_q & XW'(DECIM - 1)) == '0) && ((y_q & YW'(DECIM - 1)) == '0);
    x_d      = x_wrap ? '0 : x_q + 1'b1;
    y_d      = (x_wrap && in_frame) ? y_q + 1'b1 : y_q;
    cnt_d    = (cnt_q == CW'(PIX + 1)) ? cnt_q : cnt_q + 1'b1;
    // holding at the last slot keeps a malformed configuration from wrapping into address 0
    addr_d   = addr_q + ADDR_W'(addr_q != ADDR_W'(AMAX - 1));
    r8       = {8'd0, pixel_data_i[15:11], pixel_data_i[15:13]};
    g8       = {8'd0, pixel_data_i[10:5], pixel_data_i[10:9]};
    b8       = {8'd0, pixel_data_i[4:0], pixel_data_i[4:2]};
    // weights sum to 256, so the 8-bit maximum lands at 255*256 and never overflows 16 bits
    sum_d    = r8 * 16'd77 + g8 * 16'd150 + b8 * 16'd29;
  end
  always_ff @(posedge p_clock_i) begin
    if (!rst_n_i) begin
      state_q       <= ACTIVE;
      flush_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      s1_v_q        <= 1'b0;
      s1_sum_q      <= '0;
      s1_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      s1_v_q        <= keep;
      s1_sum_q      <= sum_d;
      s1_addr_q     <= addr_q;
      wr_en_q       <= s1_v_q;
      wr_data_q     <= 8'(s1_sum_q >> 8);
      wr_addr_q     <= s1_addr_q;
      frame_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        ACTIVE: begin
          if (accept) begin
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
          end
          if (keep) addr_q <= addr_d;
          if (frame_done_i) begin
            state_q <= FLUSH;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          flush_q <= 1'b1;
          // decision is registered on the way into SWAP so the pulse and bank update appear during SWAP
          if (flush_q) begin
            state_q       <= SWAP;
            frame_ready_q <= cnt_q == CW'(PIX);
            frame_error_q <= cnt_q != CW'(PIX);
            rd_bank_q     <= (cnt_q == CW'(PIX)) ? wr_bank_q : rd_bank_q;
            wr_bank_q     <= (cnt_q == CW'(PIX)) ? ~wr_bank_q : wr_bank_q;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
          end
        end
        default: state_q <= ACTIVE;
      endcase
    end
  end
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign wr_bank_o     = wr_bank_q;
  assign rd_bank_o     = rd_bank_q;
  assign frame_ready_o = frame_ready_q;
  assign frame_error_o = frame_error_q;
endmodule

// File: tb/tb_camera_frame_writer.sv
// tb_camera_frame_writer: scoreboard bench for camera_frame_writer on an 8x8 frame, DECIM=4.
module tb_camera_frame_writer;
  localparam int H = 8;
  localparam int V = 8;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pv = 1'b0;
  logic        fd = 1'b0;
  logic [15:0] pd = '0;
  logic        wr_en, wr_bank, rd_bank, frame_ready, frame_error;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  camera_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(D)) dut (
    .p_clock_i(clk), .rst_n_i(rst_n), .pixel_data_i(pd), .pixel_valid_i(pv), .frame_done_i(fd),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_bank_o(wr_bank),
    .rd_bank_o(rd_bank), .frame_ready_o(frame_ready), .frame_error_o(frame_error)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; bit b; int a; int d;} wr_t;
  typedef struct {int c; bit ok; bit rd; bit wb;} ev_t;
  wr_t wq[$];
  ev_t eq[$];
  wr_t w;
  ev_t e;
  int tests = 0;
  int fails = 0;
  int mx = 0, my = 0, mcnt = 0, maddr = 0;
  bit mbank = 0, mrd = 0, busy = 0;
  logic [15:0] pt[5] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};
  int          gt[5] = '{255, 76, 149, 28, 0};
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      while (wq.size() > 0 && wq[0].c < cyc) begin
        w = wq.pop_front();
        check("missed_write_cycle", cyc, w.c);
      end
      while (eq.size() > 0 && eq[0].c < cyc) begin
        e = eq.pop_front();
        check("missed_frame_event_cycle", cyc, e.c);
      end
      if (wr_en) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          w = wq.pop_front();
          check("wr_cycle", cyc, w.c);
          check("wr_bank", int'(wr_bank), int'(w.b));
          check("wr_addr", int'(wr_addr), w.a);
          check("wr_data", int'(wr_data), w.d);
        end
      end
      if (frame_ready || frame_error) begin
        check("ready_and_error_together", int'(frame_ready && frame_error), 0);
        if (eq.size() == 0) check("unexpected_frame_event", 1, 0);
        else begin
          e = eq.pop_front();
          check("event_cycle", cyc, e.c);
          check("frame_ready", int'(frame_ready), int'(e.ok));
          check("frame_error", int'(frame_error), int'(!e.ok));
          check("rd_bank", int'(rd_bank), int'(e.rd));
          check("wr_bank_after_swap", int'(wr_bank), int'(e.wb));
        end
      end
    end
  end
  task automatic drive(input bit v, input logic [15:0] d, input bit f, input int g);
    bit ok;
    @(posedge clk);
    #1;
    pv = v;
    pd = d;
    fd = f;
    if (v && !busy) begin
      mcnt++;
      if (my < V && mx % D == 0 && my % D == 0) begin
        wq.push_back('{cyc + 2, mbank, maddr, g});
        maddr++;
      end
      mx++;
      if (mx == H) begin
        mx = 0;
        my++;
      end
    end
    if (f && !busy) begin
      ok = (mcnt == H * V);
      if (ok) begin
        mrd = mbank;
        mbank = ~mbank;
      end
      eq.push_back('{cyc + 3, ok, mrd, mbank});
      mx = 0;
      my = 0;
      mcnt = 0;
      maddr = 0;
      busy = 1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 16'h0000, 0, 0);
  endtask
  task automatic frame(input int n, input int off, input bit gap, input bit solid);
    for (int i = 0; i < n; i++) begin
      if (gap) idle($urandom_range(0, 2));
      if (solid) drive(1, 16'hFFFF, 0, 255);
      else drive(1, pt[(i + off) % 5], 0, gt[(i + off) % 5]);
    end
  endtask
  // frame_done (optionally with a final pixel), a pixel during FLUSH that must be ignored, then idle
  task automatic end_frame(input bit v, input logic [15:0] d, input int g);
    drive(v, d, 1, g);
    drive(1, 16'hFFFF, 0, 255);
    idle(3);
    busy = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1 pv = ~pv;
      @(negedge clk);
      check("reset_outputs", {wr_en, wr_bank, rd_bank, frame_ready, frame_error}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    pv = 0;
    frame(64, 0, 0, 1);
    end_frame(0, 16'h0000, 0);
    frame(64, 0, 0, 0);
    end_frame(0, 16'h0000, 0);
    frame(40, 0, 0, 0);
    end_frame(0, 16'h0000, 0);
    frame(64, 1, 0, 0);
    end_frame(0, 16'h0000, 0);
    frame(70, 0, 0, 0);
    end_frame(0, 16'h0000, 0);
    frame(63, 0, 0, 0);
    end_frame(1, pt[63 % 5], gt[63 % 5]);
    frame(64, 1, 1, 0);
    end_frame(0, 16'h0000, 0);
    frame(64, 1, 1, 0);
    end_frame(0, 16'h0000, 0);
    end_frame(0, 16'h0000, 0);
    frame(10, 2, 0, 0);
    idle(3);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    mx = 0;
    my = 0;
    mcnt = 0;
    maddr = 0;
    mbank = 0;
    mrd = 0;
    @(negedge clk);
    check("rd_bank_after_midframe_reset", int'(rd_bank), 0);
    check("wr_bank_after_midframe_reset", int'(wr_bank), 0);
    frame(64, 0, 0, 0);
    end_frame(0, 16'h0000, 0);
    idle(5);
    @(negedge clk);
    check("pending_writes_left", wq.size(), 0);
    check("pending_events_left", eq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
